// File: rtl/pieo_pkg.sv
// pieo_pkg: shared definitions for the PIEO scheduler stages.
//   - default widths and NUM_FIFOS derivation
//   - element struct and pack/unpack helpers ({send_time, rank, fifo_id})
//   - wrap-aware time/rank compare helpers: later() = at-or-after,
//     after() = strictly after, both on a w-bit modular number line
//     (valid while the two values are less than 2**(w-1) apart).
package pieo_pkg;

  localparam int ID_LOG_D    = 2;
  localparam int RANK_LOG_D  = 16;
  localparam int TIME_LOG_D  = 16;
  localparam int LEN_LOG_D   = 16;
  localparam int SHIFT_LOG_D = 4;

  function automatic int num_fifos(int id_log);
    return 1 << id_log;
  endfunction

  typedef struct packed {
    logic [TIME_LOG_D-1:0] send_time;
    logic [RANK_LOG_D-1:0] rank;
    logic [ID_LOG_D-1:0]   fifo_id;
  } pieo_elem_t;

  function automatic pieo_elem_t pack_elem(logic [TIME_LOG_D-1:0] t,
                                           logic [RANK_LOG_D-1:0] r,
                                           logic [ID_LOG_D-1:0] id);
    pieo_elem_t e;
    e.send_time = t;
    e.rank      = r;
    e.fifo_id   = id;
    return e;
  endfunction

  function automatic logic [RANK_LOG_D-1:0] unpack_rank(pieo_elem_t e);
    return e.rank;
  endfunction

  // Difference a-b moved to the top of a 32-bit word so bit 31 is the sign
  // of the w-bit modular difference.
  function automatic logic later(logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] d;
    d = (a - b) << (32 - w);
    return !d[31];
  endfunction

  function automatic logic after(logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] d;
    d = (a - b) << (32 - w);
    return !d[31] && (d != 32'd0);
  endfunction

endpackage

// File: rtl/pieo_rr_arbiter.sv
// pieo_rr_arbiter: combinational round-robin pick.
//   req     : request bitmap, one bit per FIFO
//   ptr     : highest-priority index this cycle
//   gnt_oh  : one-hot grant
//   gnt_idx : grant index
//   gnt_any : some request granted
module pieo_rr_arbiter #(
  parameter int ID_LOG = 2
) (
  input  logic [(1<<ID_LOG)-1:0] req,
  input  logic [ID_LOG-1:0]      ptr,
  output logic [(1<<ID_LOG)-1:0] gnt_oh,
  output logic [ID_LOG-1:0]      gnt_idx,
  output logic                   gnt_any
);

  localparam int N = 1 << ID_LOG;

  logic [ID_LOG-1:0] cand;

  // Scan ptr, ptr+1, ... ; index addition wraps naturally at N.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = ptr;
    for (int i = 0; i < N; i++) begin
      cand = ptr + ID_LOG'(i);
      if (!gnt_any && req[cand]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand;
        gnt_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pieo_pre_enq_stfq.sv
// pieo_pre_enq_stfq: pre-enqueue stage in front of the PIEO.
// Holds one request per FIFO, picks round-robin, stamps an STFQ rank
// (start = later(V, F[g]); F[g] += len >> wshift) and a send time, and
// issues {send_time, rank, fifo_id} one cycle after the grant.
//   clk/rst           : clock, synchronous active-high reset
//   enq_*             : per-FIFO request in (valid/ready, id, head length)
//   pieo_ready        : PIEO can take an element this cycle
//   pieo_enq_*        : registered element + one-cycle strobe
//   deq_valid/rank    : PIEO dequeue, updates virtual time V
//   cur_time          : time base for pacing
//   cfg_*             : per-FIFO weight / rate shifts
// Optional: PIEO_PRE_ENQ_PACING_EN enables per-FIFO pacing (send_time from
// cur_time and eligibility E[]); without it send_time is always 0.
module pieo_pre_enq_stfq import pieo_pkg::*; #(
  parameter int ID_LOG    = ID_LOG_D,
  parameter int RANK_LOG  = RANK_LOG_D,
  parameter int TIME_LOG  = TIME_LOG_D,
  parameter int LEN_LOG   = LEN_LOG_D,
  parameter int SHIFT_LOG = SHIFT_LOG_D
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enq_valid,
  input  logic [ID_LOG-1:0]               enq_fifo_id,
  input  logic [LEN_LOG-1:0]              enq_len,
  output logic                            enq_ready,
  input  logic                            pieo_ready,
  output logic [ID_LOG+RANK_LOG+TIME_LOG-1:0] pieo_enq_element,
  output logic                            pieo_enq_trigger,
  input  logic                            deq_valid,
  input  logic [RANK_LOG-1:0]             deq_rank,
  input  logic [TIME_LOG-1:0]             cur_time,
  input  logic                            cfg_we,
  input  logic [ID_LOG-1:0]               cfg_fifo_id,
  input  logic [SHIFT_LOG-1:0]            cfg_wshift,
  input  logic [SHIFT_LOG-1:0]            cfg_rshift
);

  localparam int NUM_FIFOS = num_fifos(ID_LOG);

  logic [NUM_FIFOS-1:0]                pending;
  logic [NUM_FIFOS-1:0][LEN_LOG-1:0]   len_q;
  logic [NUM_FIFOS-1:0][RANK_LOG-1:0]  fin_q;
  logic [NUM_FIFOS-1:0][SHIFT_LOG-1:0] wshift_q;
  logic [RANK_LOG-1:0]                 vtime;
  logic [ID_LOG-1:0]                   rr_ptr;

  logic [NUM_FIFOS-1:0] gnt_oh_unused;
  logic [ID_LOG-1:0]    gnt_idx;
  logic                 gnt_any;
  logic                 issue, accept;
  logic [RANK_LOG-1:0]  start_rank, fin_next;
  logic [TIME_LOG-1:0]  send_time;

  pieo_rr_arbiter #(.ID_LOG(ID_LOG)) u_arb (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_oh  (gnt_oh_unused),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Registered pending: a FIFO issuing this cycle still looks busy, so its
  // re-request is refused until the next cycle. Accept and issue therefore
  // never target the same FIFO in one cycle.
  assign enq_ready = !rst && !pending[enq_fifo_id];
  assign accept    = enq_valid && enq_ready;
  assign issue     = pieo_ready && gnt_any;

  // vtime/fin_q/wshift_q are pre-edge values: a same-cycle dequeue or cfg
  // write only affects later issues.
  always_comb begin
    start_rank = later(32'(vtime), 32'(fin_q[gnt_idx]), RANK_LOG) ? vtime
                                                                  : fin_q[gnt_idx];
    fin_next   = start_rank + RANK_LOG'(len_q[gnt_idx] >> wshift_q[gnt_idx]);
  end

`ifdef PIEO_PRE_ENQ_PACING_EN
  logic [NUM_FIFOS-1:0][TIME_LOG-1:0]  elig_q;
  logic [NUM_FIFOS-1:0][SHIFT_LOG-1:0] rshift_q;
  logic [TIME_LOG-1:0]                 elig_next;

  always_comb begin
    send_time = later(32'(cur_time), 32'(elig_q[gnt_idx]), TIME_LOG) ? cur_time
                                                                     : elig_q[gnt_idx];
    elig_next = send_time + TIME_LOG'(len_q[gnt_idx] >> rshift_q[gnt_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elig_q   <= '0;
      rshift_q <= '0;
    end else begin
      if (issue)  elig_q[gnt_idx]       <= elig_next;
      if (cfg_we) rshift_q[cfg_fifo_id] <= cfg_rshift;
    end
  end
`else
  logic unused_pacing;
  assign unused_pacing = ^{cur_time, cfg_rshift};
  assign send_time     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pending          <= '0;
      len_q            <= '0;
      fin_q            <= '0;
      wshift_q         <= '0;
      vtime            <= '0;
      rr_ptr           <= '0;
      pieo_enq_trigger <= 1'b0;
      pieo_enq_element <= '0;
    end else begin
      pieo_enq_trigger <= issue;
      if (accept) begin
        pending[enq_fifo_id] <= 1'b1;
        len_q[enq_fifo_id]   <= enq_len;
      end
      if (issue) begin
        pending[gnt_idx] <= 1'b0;
        fin_q[gnt_idx]   <= fin_next;
        rr_ptr           <= gnt_idx + ID_LOG'(1);
        pieo_enq_element <= {send_time, start_rank, gnt_idx};
      end
      if (deq_valid) vtime                 <= deq_rank;
      if (cfg_we)    wshift_q[cfg_fifo_id] <= cfg_wshift;
    end
  end

endmodule

// File: tb/tb_pieo_pre_enq_stfq.sv
// Directed bench for pieo_pre_enq_stfq: hand-computed ranks / send times,
// checked by immediate assertions after each active edge.
module tb_pieo_pre_enq_stfq;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [1:0]  enq_fifo_id;
  logic [15:0] enq_len;
  logic        enq_ready;
  logic        pieo_ready;
  logic [33:0] pieo_enq_element;
  logic        pieo_enq_trigger;
  logic        deq_valid;
  logic [15:0] deq_rank;
  logic [15:0] cur_time;
  logic        cfg_we;
  logic [1:0]  cfg_fifo_id;
  logic [3:0]  cfg_wshift;
  logic [3:0]  cfg_rshift;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] st1, st2;

  pieo_pre_enq_stfq dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_fifo_id(enq_fifo_id), .enq_len(enq_len),
    .enq_ready(enq_ready), .pieo_ready(pieo_ready),
    .pieo_enq_element(pieo_enq_element), .pieo_enq_trigger(pieo_enq_trigger),
    .deq_valid(deq_valid), .deq_rank(deq_rank), .cur_time(cur_time),
    .cfg_we(cfg_we), .cfg_fifo_id(cfg_fifo_id),
    .cfg_wshift(cfg_wshift), .cfg_rshift(cfg_rshift)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] el(logic [15:0] st, logic [15:0] rk, logic [1:0] id);
    return {30'd0, st, rk, id};
  endfunction

  task automatic enq(input logic [1:0] id, input logic [15:0] len);
    enq_valid   = 1'b1;
    enq_fifo_id = id;
    enq_len     = len;
    step();
    enq_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enq_valid = 0; enq_fifo_id = 0; enq_len = 0; pieo_ready = 0;
    deq_valid = 0; deq_rank = 0; cur_time = 0; cfg_we = 0; cfg_fifo_id = 0;
    cfg_wshift = 0; cfg_rshift = 0;
    step(); step();
    chk("rst_trig", 64'(pieo_enq_trigger), 64'd0);
    chk("rst_elem", 64'(pieo_enq_element), 64'd0);
    chk("rst_ready", 64'(enq_ready), 64'd0);
    rst = 1'b0; #1;
    chk("ready_after_rst", 64'(enq_ready), 64'd1);

    // 1: single request, latency 1
    pieo_ready = 1'b1;
    enq(2'd2, 16'd100);
    chk("t1_no_trig_yet", 64'(pieo_enq_trigger), 64'd0);
    step();
    chk("t1_trig", 64'(pieo_enq_trigger), 64'd1);
    chk("t1_elem", 64'(pieo_enq_element), el(0, 0, 2));
    step();
    chk("t1_trig_drop", 64'(pieo_enq_trigger), 64'd0);
    chk("t1_elem_held", 64'(pieo_enq_element), el(0, 0, 2));
    enq(2'd2, 16'd5);
    step();
    chk("t1_F2_100", 64'(pieo_enq_element), el(0, 100, 2));

    // 2: round robin 0,1,3 back-to-back
    do_reset();
    pieo_ready = 1'b0;
    enq(2'd0, 16'd10);
    enq(2'd1, 16'd20);
    enq(2'd3, 16'd30);
    chk("t2_hold_trig", 64'(pieo_enq_trigger), 64'd0);
    enq_fifo_id = 2'd3; #1;
    chk("t2_busy_ready", 64'(enq_ready), 64'd0);
    pieo_ready = 1'b1;
    step(); chk("t2_g0", 64'(pieo_enq_element), el(0, 0, 0));
    chk("t2_g0_trig", 64'(pieo_enq_trigger), 64'd1);
    step(); chk("t2_g1", 64'(pieo_enq_element), el(0, 0, 1));
    step(); chk("t2_g3", 64'(pieo_enq_element), el(0, 0, 3));
    chk("t2_g3_trig", 64'(pieo_enq_trigger), 64'd1);
    step(); chk("t2_idle", 64'(pieo_enq_trigger), 64'd0);

    // 3: weighted STFQ, virtual time, same-cycle deq and cfg
    do_reset();
    cfg_we = 1; cfg_fifo_id = 2'd1; cfg_wshift = 4'd2;
    step();
    cfg_we = 0;
    pieo_ready = 1'b1;
    enq(2'd1, 16'd64); step();
    chk("t3_r0", 64'(pieo_enq_element), el(0, 0, 1));
    enq(2'd1, 16'd64); step();
    chk("t3_r16", 64'(pieo_enq_element), el(0, 16, 1));
    deq_valid = 1; deq_rank = 16'd50; step(); deq_valid = 0;
    enq(2'd1, 16'd64); step();
    chk("t3_r50", 64'(pieo_enq_element), el(0, 50, 1));
    enq(2'd1, 16'd64);
    deq_valid = 1; deq_rank = 16'd100; step(); deq_valid = 0;
    chk("t3_deq_same", 64'(pieo_enq_element), el(0, 66, 1));
    enq(2'd1, 16'd64);
    cfg_we = 1; cfg_fifo_id = 2'd1; cfg_wshift = 4'd0; step(); cfg_we = 0;
    chk("t3_cfg_same", 64'(pieo_enq_element), el(0, 100, 1));
    enq(2'd1, 16'd64); step();
    chk("t3_old_shift", 64'(pieo_enq_element), el(0, 116, 1));

    // 4: backpressure, re-request refused, len not overwritten
    do_reset();
    deq_valid = 1; deq_rank = 16'd50; step(); deq_valid = 0;
    pieo_ready = 1'b0;
    enq_valid = 1; enq_fifo_id = 2'd2; enq_len = 16'd8; step();
    enq_len = 16'd99;
    chk("t4_ready_low", 64'(enq_ready), 64'd0);
    step();
    chk("t4_no_trig", 64'(pieo_enq_trigger), 64'd0);
    chk("t4_ready_still_low", 64'(enq_ready), 64'd0);
    pieo_ready = 1'b1;
    step();
    chk("t4_trig", 64'(pieo_enq_trigger), 64'd1);
    chk("t4_elem", 64'(pieo_enq_element), el(0, 50, 2));
    chk("t4_ready_rise", 64'(enq_ready), 64'd1);
    enq_valid = 0;
    step();
    chk("t4_refused_dropped", 64'(pieo_enq_trigger), 64'd0);
    enq(2'd2, 16'd8); step();
    chk("t4_len_kept", 64'(pieo_enq_element), el(0, 58, 2));

    // 5: modular wrap of rank / finish
    do_reset();
    pieo_ready = 1'b1;
    enq(2'd0, 16'hFFF0); step();
    chk("t5_seed", 64'(pieo_enq_element), el(0, 0, 0));
    deq_valid = 1; deq_rank = 16'hFFF0; step(); deq_valid = 0;
    enq(2'd0, 16'h0020); step();
    chk("t5_fff0", 64'(pieo_enq_element), el(0, 16'hFFF0, 0));
    enq(2'd0, 16'd1); step();
    chk("t5_wrap", 64'(pieo_enq_element), el(0, 16'h0010, 0));

    // 6: pacing send time, then reset mid-stream
`ifdef PIEO_PRE_ENQ_PACING_EN
    st1 = 16'd10; st2 = 16'd30;
`else
    st1 = 16'd0;  st2 = 16'd0;
`endif
    do_reset();
    cfg_we = 1; cfg_fifo_id = 2'd0; cfg_wshift = 4'd0; cfg_rshift = 4'd1;
    step(); cfg_we = 0;
    cur_time = 16'd10;
    pieo_ready = 1'b1;
    enq(2'd0, 16'd40); step();
    chk("t6_send1", 64'(pieo_enq_element), el(st1, 0, 0));
    enq(2'd0, 16'd40); step();
    chk("t6_send2", 64'(pieo_enq_element), el(st2, 40, 0));
    pieo_ready = 1'b0;
    enq(2'd1, 16'd5);
    pieo_ready = 1'b1; rst = 1'b1;
    step();
    chk("t6_rst_trig", 64'(pieo_enq_trigger), 64'd0);
    chk("t6_rst_elem", 64'(pieo_enq_element), 64'd0);
    chk("t6_rst_ready", 64'(enq_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("t6_pending_cleared", 64'(pieo_enq_trigger), 64'd0);
    enq_fifo_id = 2'd1; #1;
    chk("t6_ready_back", 64'(enq_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
